// File: rtl/servo_pwm_pkg.sv
// Shared definitions for the multi-channel servo PWM block: command op-codes and the
// datapath width used for counter and pulse-width arithmetic.
package servo_pwm_pkg;

    localparam int unsigned LARGURA_W = 32;

    localparam logic [1:0] OP_SET      = 2'b00;
    localparam logic [1:0] OP_DIREITA  = 2'b01;
    localparam logic [1:0] OP_ESQUERDA = 2'b10;
    localparam logic [1:0] OP_NOP      = 2'b11;

endpackage

// File: rtl/servo_pwm_multicanal_canal.sv
// One servo channel: saturating position register, target width, slew-limited width
// register (updated only on the period boundary) and registered pulse compare.
module canal_pwm
    import servo_pwm_pkg::*;
#(
    parameter int unsigned N_POS       = 8,
    parameter int unsigned W_POS       = $clog2(N_POS),
    parameter int unsigned LARGURA_MIN = 50_000,
    parameter int unsigned PASSO       = 7_000,
    parameter int unsigned RAMPA       = 0,
    parameter int unsigned POS_INICIAL = 0
) (
    input  logic                 clock,
    input  logic                 zera,
    input  logic                 cmd_en,
    input  logic [1:0]           cmd_op,
    input  logic [W_POS-1:0]     cmd_pos,
    input  logic                 enable_mov,
    input  logic [LARGURA_W-1:0] contagem,
    input  logic                 fronteira,
    output logic [W_POS-1:0]     pos,
    output logic                 pwm,
    output logic                 em_movimento
);

    localparam logic [W_POS-1:0]     POS_MAX  = W_POS'(N_POS - 1);
    localparam logic [W_POS-1:0]     POS_RST  = W_POS'(POS_INICIAL);
    localparam logic [LARGURA_W-1:0] LARG_RST = LARGURA_W'(LARGURA_MIN + POS_INICIAL * PASSO);
    localparam logic [LARGURA_W-1:0] RAMPA_L  = LARGURA_W'(RAMPA);

    logic [W_POS-1:0]     pos_q, pos_d, pos_set;
    logic [LARGURA_W-1:0] largura_q, largura_d, alvo;
    logic                 pwm_q, pwm_d;

    // Saturation on a direct set is only needed when N_POS leaves unused codes.
    if (N_POS == (1 << W_POS)) begin : g_pos_pot2
        assign pos_set = cmd_pos;
    end else begin : g_pos_sat
        assign pos_set = (cmd_pos > POS_MAX) ? POS_MAX : cmd_pos;
    end

    always_comb begin
        pos_d = pos_q;
        if (cmd_en) begin
            unique case (cmd_op)
                OP_SET:      pos_d = pos_set;
                OP_DIREITA:  if (enable_mov && pos_q != POS_MAX) pos_d = pos_q + 1'b1;
                OP_ESQUERDA: if (enable_mov && pos_q != '0) pos_d = pos_q - 1'b1;
                default:     pos_d = pos_q;
            endcase
        end
    end

    assign alvo = LARGURA_W'(LARGURA_MIN) + LARGURA_W'(pos_q) * LARGURA_W'(PASSO);

    // Width only moves at the boundary, so a pulse in flight is never cut or stretched.
    always_comb begin
        largura_d = largura_q;
        if (fronteira) begin
            if (RAMPA == 0) begin
                largura_d = alvo;
            end else if (alvo > largura_q) begin
                largura_d = (alvo - largura_q > RAMPA_L) ? largura_q + RAMPA_L : alvo;
            end else begin
                largura_d = (largura_q - alvo > RAMPA_L) ? largura_q - RAMPA_L : alvo;
            end
        end
        pwm_d = (contagem < largura_q);
    end

    always_ff @(posedge clock) begin
        if (zera) begin
            pos_q     <= POS_RST;
            largura_q <= LARG_RST;
            pwm_q     <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            largura_q <= largura_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pos          = pos_q;
    assign pwm          = pwm_q;
    assign em_movimento = (largura_q != alvo);

endmodule

// File: rtl/servo_pwm_multicanal.sv
// Multi-channel servo PWM: shared period counter, command decode and one canal_pwm per
// channel; outputs are packed per channel.
module servo_pwm_multicanal
    import servo_pwm_pkg::*;
#(
    parameter int unsigned CONF_PERIODO = 1_000_000,
    parameter int unsigned N_CANAIS     = 4,
    parameter int unsigned N_POS        = 8,
    parameter int unsigned W_POS        = $clog2(N_POS),
    parameter int unsigned LARGURA_MIN  = 50_000,
    parameter int unsigned PASSO        = 7_000,
    parameter int unsigned RAMPA        = 0,
    parameter int unsigned POS_INICIAL  = 0,
    parameter int unsigned W_CANAL      = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
    input  logic                      clock,
    input  logic                      zera,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [W_CANAL-1:0]        cmd_canal,
    input  logic [1:0]                cmd_op,
    input  logic [W_POS-1:0]          cmd_pos,
    input  logic                      enable_mov,
    output logic [N_CANAIS-1:0]       pwm,
    output logic [N_CANAIS*W_POS-1:0] pos,
    output logic [N_CANAIS-1:0]       em_movimento,
    output logic                      fim_periodo,
    output logic                      db_pwm
);

    localparam logic [LARGURA_W-1:0] CONT_MAX = LARGURA_W'(CONF_PERIODO - 1);

    logic [LARGURA_W-1:0] contagem_q, contagem_d;
    logic                 fim_periodo_q, fim_periodo_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 fronteira, aceita;

    assign fronteira = (contagem_q == CONT_MAX);
    assign aceita    = cmd_valid && cmd_ready_q;

    always_comb begin
        contagem_d    = fronteira ? '0 : contagem_q + 1'b1;
        fim_periodo_d = fronteira;
        cmd_ready_d   = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (zera) begin
            contagem_q    <= '0;
            fim_periodo_q <= 1'b0;
            cmd_ready_q   <= 1'b0;
        end else begin
            contagem_q    <= contagem_d;
            fim_periodo_q <= fim_periodo_d;
            cmd_ready_q   <= cmd_ready_d;
        end
    end

    // Out-of-range channel numbers match no instance, so such commands are absorbed.
    for (genvar c = 0; c < N_CANAIS; c++) begin : g_canal
        canal_pwm #(
            .N_POS       (N_POS),
            .W_POS       (W_POS),
            .LARGURA_MIN (LARGURA_MIN),
            .PASSO       (PASSO),
            .RAMPA       (RAMPA),
            .POS_INICIAL (POS_INICIAL)
        ) u_canal (
            .clock        (clock),
            .zera         (zera),
            .cmd_en       (aceita && (LARGURA_W'(cmd_canal) == LARGURA_W'(c))),
            .cmd_op       (cmd_op),
            .cmd_pos      (cmd_pos),
            .enable_mov   (enable_mov),
            .contagem     (contagem_q),
            .fronteira    (fronteira),
            .pos          (pos[c*W_POS +: W_POS]),
            .pwm          (pwm[c]),
            .em_movimento (em_movimento[c])
        );
    end

    assign cmd_ready   = cmd_ready_q;
    assign fim_periodo = fim_periodo_q;
    assign db_pwm      = pwm[0];

endmodule
